// File: rtl/pong_match_ctrl_if.sv
// Bus between the Pong match controller and the game/ball/display logic.
// master drives positions and buttons; slave is the match controller.
interface pong_match_ctrl_if #(
   parameter int COORD_W = 6,
   parameter int SCORE_W = 4
);
   logic               i_Frame_Tick;
   logic               i_Game_Start;
   logic [COORD_W-1:0] i_Ball_X;
   logic [COORD_W-1:0] i_Ball_Y;
   logic [COORD_W-1:0] i_Paddle_Y_P1;
   logic [COORD_W-1:0] i_Paddle_Y_P2;
   logic               o_Game_Active;
   logic               o_Serve_Dir;
   logic [SCORE_W-1:0] o_P1_Score;
   logic [SCORE_W-1:0] o_P2_Score;
   logic               o_Point_P1;
   logic               o_Point_P2;
   logic               o_Match_Over;
   logic               o_Winner;
   logic [2:0]         o_State;

   modport master (
      output i_Frame_Tick, i_Game_Start, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
      input  o_Game_Active, o_Serve_Dir, o_P1_Score, o_P2_Score, o_Point_P1, o_Point_P2,
             o_Match_Over, o_Winner, o_State
   );

   modport slave (
      input  i_Frame_Tick, i_Game_Start, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
      output o_Game_Active, o_Serve_Dir, o_P1_Score, o_P2_Score, o_Point_P1, o_Point_P2,
             o_Match_Over, o_Winner, o_State
   );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve countdown, scoring, match-win and serve direction.
// Optional win-by-two with deuce enabled by defining PONG_MATCH_WIN_BY_TWO_EN.
module pong_match_ctrl #(
   parameter int GAME_WIDTH    = 40,
   parameter int PADDLE_HEIGHT = 6,
   parameter int PADDLE_COL_P1 = 0,
   parameter int PADDLE_COL_P2 = GAME_WIDTH - 1,
   parameter int COORD_W       = 6,
   parameter int SCORE_LIMIT   = 9,
   parameter int SCORE_W       = 4,
   parameter int SERVE_FRAMES  = 60,
   parameter int CNT_W         = 7
) (
   input logic              i_Clk,
   input logic              i_Rst_L,
   pong_match_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE      = 3'd1,
      RUNNING    = 3'd2,
      POINT      = 3'd3,
      MATCH_OVER = 3'd4
   } state_t;

   localparam logic [COORD_W-1:0] COL_P1     = COORD_W'(PADDLE_COL_P1);
   localparam logic [COORD_W-1:0] COL_P2     = COORD_W'(PADDLE_COL_P2);
   localparam logic [COORD_W:0]   PAD_H      = (COORD_W+1)'(PADDLE_HEIGHT);
   localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [SCORE_W-1:0] LIMIT      = SCORE_W'(SCORE_LIMIT);
   localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

   state_t             state;
   logic               start_q;
   logic               start_edge;
   logic [CNT_W-1:0]   cnt;
   logic               p1_scored;
   logic [COORD_W:0]   p1_bot;
   logic [COORD_W:0]   p2_bot;
   logic               miss_p1;
   logic               miss_p2;
   logic [SCORE_W-1:0] scorer;
   logic [SCORE_W-1:0] other;
   logic               win;

   // Paddle bottom is computed one bit wider so a paddle near the last row never wraps.
   assign p1_bot  = {1'b0, bus.i_Paddle_Y_P1} + PAD_H;
   assign p2_bot  = {1'b0, bus.i_Paddle_Y_P2} + PAD_H;
   assign miss_p1 = (bus.i_Ball_X == COL_P1) &&
                    ((bus.i_Ball_Y < bus.i_Paddle_Y_P1) || ({1'b0, bus.i_Ball_Y} > p1_bot));
   assign miss_p2 = (bus.i_Ball_X == COL_P2) &&
                    ((bus.i_Ball_Y < bus.i_Paddle_Y_P2) || ({1'b0, bus.i_Ball_Y} > p2_bot));

   assign scorer = p1_scored ? bus.o_P1_Score : bus.o_P2_Score;
   assign other  = p1_scored ? bus.o_P2_Score : bus.o_P1_Score;

`ifdef PONG_MATCH_WIN_BY_TWO_EN
   localparam logic [SCORE_W-1:0] LIMIT_M1 = SCORE_W'(SCORE_LIMIT - 1);
   localparam logic [SCORE_W:0]   LEAD_MIN = (SCORE_W+1)'(2);
   logic deuce;
   assign win   = (scorer >= LIMIT) && ({1'b0, scorer} >= ({1'b0, other} + LEAD_MIN));
   assign deuce = (bus.o_P1_Score == LIMIT) && (bus.o_P2_Score == LIMIT);
`else
   assign win   = (scorer == LIMIT);
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state             <= IDLE;
         start_q           <= 1'b1;
         start_edge        <= 1'b0;
         cnt               <= '0;
         p1_scored         <= 1'b0;
         bus.o_Game_Active <= 1'b0;
         bus.o_Serve_Dir   <= 1'b1;
         bus.o_P1_Score    <= '0;
         bus.o_P2_Score    <= '0;
         bus.o_Point_P1    <= 1'b0;
         bus.o_Point_P2    <= 1'b0;
         bus.o_Match_Over  <= 1'b0;
         bus.o_Winner      <= 1'b0;
         bus.o_State       <= '0;
      end else begin
         // start_q resets high so a button held through reset is not seen as an edge
         start_q           <= bus.i_Game_Start;
         start_edge        <= bus.i_Game_Start & ~start_q;
         bus.o_Point_P1    <= 1'b0;
         bus.o_Point_P2    <= 1'b0;
         bus.o_State       <= state;
         bus.o_Game_Active <= (state == RUNNING);
         bus.o_Match_Over  <= (state == MATCH_OVER);

         case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= SERVE;
                  cnt   <= SERVE_LOAD;
               end
            end
            SERVE: begin
               if (cnt == '0) state <= RUNNING;
               else if (bus.i_Frame_Tick) cnt <= cnt - CNT_ONE;
            end
            RUNNING: begin
               if (miss_p1) begin
                  state          <= POINT;
                  p1_scored      <= 1'b0;
                  bus.o_P2_Score <= bus.o_P2_Score + SCORE_ONE;
                  bus.o_Point_P2 <= 1'b1;
               end else if (miss_p2) begin
                  state          <= POINT;
                  p1_scored      <= 1'b1;
                  bus.o_P1_Score <= bus.o_P1_Score + SCORE_ONE;
                  bus.o_Point_P1 <= 1'b1;
               end
            end
            POINT: begin
               if (win) begin
                  state        <= MATCH_OVER;
                  bus.o_Winner <= ~p1_scored;
               end else begin
`ifdef PONG_MATCH_WIN_BY_TWO_EN
                  if (deuce) begin
                     bus.o_P1_Score <= LIMIT_M1;
                     bus.o_P2_Score <= LIMIT_M1;
                  end
`endif
                  state           <= SERVE;
                  cnt             <= SERVE_LOAD;
                  bus.o_Serve_Dir <= p1_scored;
               end
            end
            MATCH_OVER: begin
               if (start_edge) begin
                  state           <= SERVE;
                  cnt             <= SERVE_LOAD;
                  bus.o_P1_Score  <= '0;
                  bus.o_P2_Score  <= '0;
                  bus.o_Winner    <= 1'b0;
                  bus.o_Serve_Dir <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: serve timing, scoring, priority, match win,
// deuce (when PONG_MATCH_WIN_BY_TWO_EN is defined) and asynchronous reset.
module tb_pong_match_ctrl;
   localparam int COORD_W = 6;
   localparam int SCORE_W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   pong_match_ctrl_if #(.COORD_W(COORD_W), .SCORE_W(SCORE_W)) bus ();
   pong_match_ctrl_if #(.COORD_W(COORD_W), .SCORE_W(SCORE_W)) bus2 ();

   pong_match_ctrl #(.SERVE_FRAMES(3)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus.slave)
   );

   // Both paddles on column 0 so a single ball position misses both at once.
   pong_match_ctrl #(.PADDLE_COL_P2(0), .SERVE_FRAMES(0)) dut2 (
      .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus2.slave)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic serve_to_running();
      bus.i_Frame_Tick = 1'b1;
      step(3);
      bus.i_Frame_Tick = 1'b0;
      step(2);
   endtask

   task automatic press_start();
      bus.i_Game_Start = 1'b1;
      step(1);
      bus.i_Game_Start = 1'b0;
      step(1);
   endtask

   task automatic score_point(input bit p1_scores);
      bus.i_Ball_X = p1_scores ? 6'd39 : 6'd0;
      bus.i_Ball_Y = 6'd20;
      step(1);
      bus.i_Ball_X = 6'd20;
      step(2);
      if (bus.o_State == 3'd1) serve_to_running();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      checks++; if (bus.o_State !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.o_State); else passed++;
      checks++; if (bus.o_P1_Score !== 4'd0 || bus.o_P2_Score !== 4'd0) $display("FAIL reset_scores: got %0d/%0d want 0/0", bus.o_P1_Score, bus.o_P2_Score); else passed++;
      checks++; if (bus.o_Serve_Dir !== 1'b1) $display("FAIL reset_dir: got %0d want 1", bus.o_Serve_Dir); else passed++;
      checks++; if ({bus.o_Game_Active, bus.o_Match_Over, bus.o_Winner, bus.o_Point_P1, bus.o_Point_P2} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {bus.o_Game_Active, bus.o_Match_Over, bus.o_Winner, bus.o_Point_P1, bus.o_Point_P2}); else passed++;
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_both_miss();
      bus2.i_Game_Start = 1'b1;
      step(1);
      bus2.i_Game_Start = 1'b0;
      step(1);
      checks++; if (bus2.o_State !== 3'd0) $display("FAIL zero_serve_idle: got %0d want 0", bus2.o_State); else passed++;
      step(1);
      checks++; if (bus2.o_State !== 3'd1 || bus2.o_Game_Active !== 1'b0) $display("FAIL zero_serve_serve: got %0d/%0d want 1/0", bus2.o_State, bus2.o_Game_Active); else passed++;
      step(1);
      checks++; if (bus2.o_State !== 3'd2 || bus2.o_Game_Active !== 1'b1) $display("FAIL zero_serve_run: got %0d/%0d want 2/1", bus2.o_State, bus2.o_Game_Active); else passed++;
      bus2.i_Ball_X = 6'd0;
      bus2.i_Ball_Y = 6'd20;
      step(1);
      bus2.i_Ball_X = 6'd20;
      checks++; if (bus2.o_P1_Score !== 4'd0 || bus2.o_P2_Score !== 4'd1) $display("FAIL both_miss_scores: got %0d/%0d want 0/1", bus2.o_P1_Score, bus2.o_P2_Score); else passed++;
      checks++; if (bus2.o_Point_P1 !== 1'b0 || bus2.o_Point_P2 !== 1'b1) $display("FAIL both_miss_pulses: got %0d/%0d want 0/1", bus2.o_Point_P1, bus2.o_Point_P2); else passed++;
      step(2);
   endtask

   task automatic test_serve();
      bus.i_Game_Start = 1'b1;
      step(1);
      bus.i_Game_Start = 1'b0;
      checks++; if (bus.o_State !== 3'd0) $display("FAIL start_edge_reg: got %0d want 0", bus.o_State); else passed++;
      step(2);
      checks++; if (bus.o_State !== 3'd1 || bus.o_Game_Active !== 1'b0) $display("FAIL serve_entry: got %0d/%0d want 1/0", bus.o_State, bus.o_Game_Active); else passed++;
      for (int i = 0; i < 3; i++) begin
         bus.i_Frame_Tick = 1'b1;
         step(1);
         bus.i_Frame_Tick = 1'b0;
         step(1);
         checks++; if (bus.o_Game_Active !== 1'b0) $display("FAIL serve_early_active: tick %0d got %0d want 0", i, bus.o_Game_Active); else passed++;
      end
      step(1);
      checks++; if (bus.o_Game_Active !== 1'b1 || bus.o_State !== 3'd2) $display("FAIL serve_running: got %0d/%0d want 1/2", bus.o_Game_Active, bus.o_State); else passed++;
   endtask

   task automatic test_point_p2();
      bus.i_Ball_X = 6'd0;
      bus.i_Ball_Y = 6'd11;
      step(1);
      checks++; if (bus.o_Point_P2 !== 1'b0 || bus.o_P2_Score !== 4'd0) $display("FAIL hit_edge: got %0d/%0d want 0/0", bus.o_Point_P2, bus.o_P2_Score); else passed++;
      bus.i_Ball_Y = 6'd20;
      step(1);
      bus.i_Ball_X = 6'd20;
      checks++; if (bus.o_Point_P2 !== 1'b1 || bus.o_P2_Score !== 4'd1 || bus.o_P1_Score !== 4'd0) $display("FAIL p2_point: got %0d/%0d/%0d want 1/1/0", bus.o_Point_P2, bus.o_P2_Score, bus.o_P1_Score); else passed++;
      step(1);
      checks++; if (bus.o_Point_P2 !== 1'b0 || bus.o_Serve_Dir !== 1'b0 || bus.o_State !== 3'd3) $display("FAIL p2_point_after: got %0d/%0d/%0d want 0/0/3", bus.o_Point_P2, bus.o_Serve_Dir, bus.o_State); else passed++;
      step(1);
      checks++; if (bus.o_State !== 3'd1) $display("FAIL point_to_serve: got %0d want 1", bus.o_State); else passed++;
      serve_to_running();
   endtask

   task automatic test_match_win();
      bus.i_Ball_X = 6'd39;
      bus.i_Ball_Y = 6'd20;
      step(1);
      bus.i_Ball_X = 6'd20;
      checks++; if (bus.o_Point_P1 !== 1'b1 || bus.o_Point_P2 !== 1'b0 || bus.o_P1_Score !== 4'd1) $display("FAIL p1_point: got %0d/%0d/%0d want 1/0/1", bus.o_Point_P1, bus.o_Point_P2, bus.o_P1_Score); else passed++;
      step(2);
      checks++; if (bus.o_Serve_Dir !== 1'b1 || bus.o_State !== 3'd1) $display("FAIL p1_point_dir: got %0d/%0d want 1/1", bus.o_Serve_Dir, bus.o_State); else passed++;
      serve_to_running();
      for (int i = 0; i < 8; i++) score_point(1'b1);
      checks++; if (bus.o_State !== 3'd4 || bus.o_Match_Over !== 1'b1 || bus.o_Winner !== 1'b0) $display("FAIL match_over: got %0d/%0d/%0d want 4/1/0", bus.o_State, bus.o_Match_Over, bus.o_Winner); else passed++;
      checks++; if (bus.o_P1_Score !== 4'd9 || bus.o_P2_Score !== 4'd1) $display("FAIL match_scores: got %0d/%0d want 9/1", bus.o_P1_Score, bus.o_P2_Score); else passed++;
      bus.i_Ball_X = 6'd0;
      bus.i_Frame_Tick = 1'b1;
      step(3);
      bus.i_Ball_X = 6'd20;
      bus.i_Frame_Tick = 1'b0;
      checks++; if (bus.o_P1_Score !== 4'd9 || bus.o_P2_Score !== 4'd1 || bus.o_State !== 3'd4) $display("FAIL match_hold: got %0d/%0d/%0d want 9/1/4", bus.o_P1_Score, bus.o_P2_Score, bus.o_State); else passed++;
      press_start();
      checks++; if (bus.o_P1_Score !== 4'd0 || bus.o_P2_Score !== 4'd0 || bus.o_Serve_Dir !== 1'b1) $display("FAIL restart_clear: got %0d/%0d/%0d want 0/0/1", bus.o_P1_Score, bus.o_P2_Score, bus.o_Serve_Dir); else passed++;
      step(1);
      checks++; if (bus.o_State !== 3'd1 || bus.o_Match_Over !== 1'b0) $display("FAIL restart_serve: got %0d/%0d want 1/0", bus.o_State, bus.o_Match_Over); else passed++;
      serve_to_running();
   endtask

   task automatic test_deuce();
      for (int i = 0; i < 8; i++) begin
         score_point(1'b1);
         score_point(1'b0);
      end
      checks++; if (bus.o_P1_Score !== 4'd8 || bus.o_P2_Score !== 4'd8 || bus.o_State !== 3'd2) $display("FAIL eight_all: got %0d/%0d/%0d want 8/8/2", bus.o_P1_Score, bus.o_P2_Score, bus.o_State); else passed++;
`ifdef PONG_MATCH_WIN_BY_TWO_EN
      score_point(1'b1);
      checks++; if (bus.o_P1_Score !== 4'd9 || bus.o_P2_Score !== 4'd8 || bus.o_State !== 3'd2) $display("FAIL adv_p1: got %0d/%0d/%0d want 9/8/2", bus.o_P1_Score, bus.o_P2_Score, bus.o_State); else passed++;
      score_point(1'b0);
      checks++; if (bus.o_P1_Score !== 4'd8 || bus.o_P2_Score !== 4'd8 || bus.o_State !== 3'd2) $display("FAIL deuce: got %0d/%0d/%0d want 8/8/2", bus.o_P1_Score, bus.o_P2_Score, bus.o_State); else passed++;
      score_point(1'b1);
      score_point(1'b1);
      checks++; if (bus.o_P1_Score !== 4'd10 || bus.o_P2_Score !== 4'd8) $display("FAIL win_by_two_scores: got %0d/%0d want 10/8", bus.o_P1_Score, bus.o_P2_Score); else passed++;
      checks++; if (bus.o_State !== 3'd4 || bus.o_Winner !== 1'b0) $display("FAIL win_by_two_winner: got %0d/%0d want 4/0", bus.o_State, bus.o_Winner); else passed++;
`else
      score_point(1'b0);
      checks++; if (bus.o_P1_Score !== 4'd8 || bus.o_P2_Score !== 4'd9) $display("FAIL p2_win_scores: got %0d/%0d want 8/9", bus.o_P1_Score, bus.o_P2_Score); else passed++;
      checks++; if (bus.o_State !== 3'd4 || bus.o_Winner !== 1'b1) $display("FAIL p2_win_winner: got %0d/%0d want 4/1", bus.o_State, bus.o_Winner); else passed++;
      press_start();
      checks++; if (bus.o_Winner !== 1'b0 || bus.o_P2_Score !== 4'd0) $display("FAIL winner_clear: got %0d/%0d want 0/0", bus.o_Winner, bus.o_P2_Score); else passed++;
`endif
   endtask

   task automatic test_async_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(2);
      press_start();
      step(1);
      checks++; if (bus.o_State !== 3'd1) $display("FAIL pre_reset_serve: got %0d want 1", bus.o_State); else passed++;
      bus.i_Game_Start = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.o_State !== 3'd0) $display("FAIL reset_mid_serve: got %0d want 0", bus.o_State); else passed++;
      step(1);
      rst_n = 1'b1;
      step(4);
      checks++; if (bus.o_State !== 3'd0) $display("FAIL held_start: got %0d want 0", bus.o_State); else passed++;
      bus.i_Game_Start = 1'b0;
      step(1);
      press_start();
      step(1);
      serve_to_running();
      score_point(1'b0);
      checks++; if (bus.o_P2_Score !== 4'd1 || bus.o_Game_Active !== 1'b1) $display("FAIL pre_reset_run: got %0d/%0d want 1/1", bus.o_P2_Score, bus.o_Game_Active); else passed++;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.o_Game_Active !== 1'b0 || bus.o_P2_Score !== 4'd0 || bus.o_State !== 3'd0 || bus.o_Serve_Dir !== 1'b1) $display("FAIL reset_mid_run: got %0d/%0d/%0d/%0d want 0/0/0/1", bus.o_Game_Active, bus.o_P2_Score, bus.o_State, bus.o_Serve_Dir); else passed++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.i_Frame_Tick   = 1'b0;
      bus.i_Game_Start   = 1'b0;
      bus.i_Ball_X       = 6'd20;
      bus.i_Ball_Y       = 6'd20;
      bus.i_Paddle_Y_P1  = 6'd5;
      bus.i_Paddle_Y_P2  = 6'd5;
      bus2.i_Frame_Tick  = 1'b0;
      bus2.i_Game_Start  = 1'b0;
      bus2.i_Ball_X      = 6'd20;
      bus2.i_Ball_Y      = 6'd20;
      bus2.i_Paddle_Y_P1 = 6'd5;
      bus2.i_Paddle_Y_P2 = 6'd5;
      test_reset();
      test_both_miss();
      test_serve();
      test_point_p2();
      test_match_win();
      test_deuce();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the Pong game: replaces the fixed single-point state machine with a full match flow (serve countdown, per-point scoring, match-win detection, alternating serve direction). Sits between the ball/paddle controllers and the video/score display logic. It consumes ball and paddle positions in game-grid units and drives the ball controller's game-active enable plus score and status outputs.

## Interface
- GAME_WIDTH, 40, grid columns
- PADDLE_HEIGHT, 6, paddle span in rows; hit range is Y..Y+PADDLE_HEIGHT inclusive
- PADDLE_COL_P1, 0, P1 paddle column
- PADDLE_COL_P2, GAME_WIDTH-1, P2 paddle column
- COORD_W, 6, width of position inputs
- SCORE_LIMIT, 9, points needed to win; must be < 2^SCORE_W - 1
- SCORE_W, 4, score width
- SERVE_FRAMES, 60, frame ticks of pre-serve delay, 0 allowed
- CNT_W, 7, serve counter width, holds SERVE_FRAMES
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Frame_Tick  in  1  one-cycle pulse per video frame
- i_Game_Start  in  1  start button, level, synchronised upstream
- i_Ball_X, i_Ball_Y  in  COORD_W  ball position
- i_Paddle_Y_P1, i_Paddle_Y_P2  in  COORD_W  paddle top rows
- o_Game_Active  out  1  ball-motion enable
- o_Serve_Dir  out  1  1 = serve toward P2, 0 = toward P1
- o_P1_Score, o_P2_Score  out  SCORE_W  current scores
- o_Point_P1, o_Point_P2  out  1  one-cycle pulse when that player scores
- o_Match_Over  out  1  high in MATCH_OVER
- o_Winner  out  1  0 = P1, 1 = P2; valid while o_Match_Over
- o_State  out  3  current state encoding

## Operation
- States: IDLE=0, SERVE=1, RUNNING=2, POINT=3, MATCH_OVER=4; codes 5-7 return to IDLE next cycle.
- Start is a registered rising edge of i_Game_Start; a held button does not retrigger.
- IDLE: start edge -> SERVE, counter loaded with SERVE_FRAMES.
- SERVE: counter==0 -> RUNNING; else decrement on i_Frame_Tick.
- RUNNING: o_Game_Active=1. P1 miss = Ball_X==PADDLE_COL_P1 and (Ball_Y<Paddle_Y_P1 or Ball_Y>Paddle_Y_P1+PADDLE_HEIGHT); P2 miss likewise. Sum computed in COORD_W+1 bits, no wrap. P1 miss has priority over a simultaneous P2 miss. Miss -> POINT; the other player's score increments and point pulse asserts on that same edge.
- POINT (one cycle): win condition -> MATCH_OVER with o_Winner set; else -> SERVE, counter reloaded, o_Serve_Dir set toward the player who conceded (P1 scored -> 1).
- MATCH_OVER: scores held; start edge clears both scores and o_Winner, -> SERVE, o_Serve_Dir=1.
- Start edges outside IDLE/MATCH_OVER and frame ticks outside SERVE are ignored.
- Reset: state IDLE, scores 0, counter 0, o_Serve_Dir=1, all pulses/flags 0, o_Winner=0.

## Timing
- All outputs registered; o_Game_Active/o_Match_Over/o_State valid the cycle after the state register updates.
- Start edge to SERVE: 2 cycles after i_Game_Start rises (edge register + state register).
- SERVE to RUNNING: SERVE_FRAMES frame ticks plus 1 cycle; SERVE_FRAMES=0 gives exactly 1 cycle in SERVE.
- Miss to score/pulse: 1 cycle; POINT lasts exactly 1 cycle.
- Reset assertion is asynchronous at any point, mid-serve or mid-rally included; release takes effect on the next i_Clk edge.

## Configuration
- PONG_MATCH_WIN_BY_TWO_EN undefined: win when the scoring player's score equals SCORE_LIMIT.
- PONG_MATCH_WIN_BY_TWO_EN defined: win needs score >= SCORE_LIMIT and a lead of 2 or more. A tie at SCORE_LIMIT sets both scores to SCORE_LIMIT-1 in POINT (deuce), so scores never exceed SCORE_LIMIT+1.

## Test plan
- Reset, start pulse, SERVE_FRAMES=3 -> RUNNING after exactly 3 ticks +1 cycle; o_Game_Active rises then, not before.
- RUNNING, Ball_X=0, Ball_Y=20, Paddle_Y_P1=5 -> o_Point_P2 single pulse, P2 score 0->1, o_Serve_Dir=0; Ball_Y=11 (edge of hit range) -> no point.
- Both misses forced the same cycle -> only P2 scores.
- P1 wins 9 points, no macro -> MATCH_OVER, o_Winner=0, scores 9/x held; start edge -> scores 0/0, SERVE.
- Macro defined, reach 8/8, then P1, then P2 -> 8/8 via deuce; P1, P1 -> 10/8, o_Winner=0.
- Reset asserted mid-SERVE and mid-RUNNING -> outputs immediately return to reset values; held start button after release does not start the game.
